servo_ramp: RTL and testbench
=============================

SERVO_RAMP -- requirements
Module: servo_ramp

Interface
REQ-001 Parameter PERIOD, default 32'd1000000, PWM period value written to every T register (20 ms at 50 MHz).
REQ-002 Parameter DMID, default 32'd75000, power-up duty written to every D register and initial current duty.
REQ-003 Parameter DMIN, default 32'd50000, lowest duty ever written; DMAX, default 32'd100000, highest duty ever written.
REQ-004 Parameter STEP_DIV, default 32'd50000, clock cycles between successive ramp writes (1 ms at 50 MHz).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  block can accept a command this cycle.
REQ-009 cmd_ch  input  3  target servo channel 0..7.
REQ-010 cmd_target  input  32  requested final duty, in clock cycles.
REQ-011 cmd_step  input  16  duty increment per ramp write; 0 = jump directly.
REQ-012 busy  output  1  initialisation or ramp in progress.
REQ-013 done  output  1  one-cycle pulse when a command completes.
REQ-014 cs, wr, rd  output  1 each  register-bus strobes toward the 8-channel PWM peripheral; rd always 0.
REQ-015 addr  output  8  byte address: E_n = 12*n, T_n = 12*n+4, D_n = 12*n+8.
REQ-016 bus_d  output  32  write data, valid while cs&&wr.

Function
REQ-017 Every bus write SHALL be exactly one cycle with cs=wr=1, addr and bus_d stable; cs=wr=0, addr=0, bus_d=0 otherwise.
REQ-018 FSM states SHALL be INIT, IDLE, WAIT, WRITE; INIT entered from reset.
REQ-019 INIT SHALL issue 24 writes on consecutive cycles: for n=0..7 in order T_n=PERIOD, D_n=DMID, E_n=1, then go to IDLE.
REQ-020 cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 in INIT, WAIT, WRITE.
REQ-021 A command is accepted on a cycle with cmd_valid&&cmd_ready; channel, clamped target and step are latched; cmd inputs ignored otherwise.
REQ-022 Target SHALL be clamped: below DMIN -> DMIN, above DMAX -> DMAX.
REQ-023 An 8-entry table SHALL hold the last duty written per channel; updated on each D write.
REQ-024 If cmd_step==0 or clamped target equals current duty, one D_ch write of the target SHALL occur the cycle after acceptance, followed by done.
REQ-025 Otherwise WAIT SHALL count STEP_DIV cycles from acceptance; on expiry WRITE issues D_ch = next value, so write k occurs STEP_DIV*k cycles after acceptance.
REQ-026 Next value: if |target-cur| <= step then target, else cur+step (rising) or cur-step (falling); 32-bit unsigned, no wrap or overshoot.
REQ-027 After the write that reaches target, done SHALL pulse on the following cycle and FSM SHALL return to IDLE; otherwise back to WAIT with counter restarted.
REQ-028 Commands offered while busy SHALL be held off (cmd_ready=0), never dropped or merged.
REQ-029 Only one channel ramps at a time; other channels' registers are never rewritten after INIT.

Reset
REQ-030 rst SHALL force, next edge: state INIT, cs=wr=rd=0, addr=0, bus_d=0, done=0, cmd_ready=0, busy=1, counter=0, duty table all DMID.
REQ-031 rst mid-ramp or mid-INIT SHALL abandon the operation without done and restart full INIT after release.

Structure
REQ-032 Shared package servo_pkg SHALL hold register offset constants (OFF_E=0, OFF_T=4, OFF_D=8, CH_STRIDE=12) and the FSM state enumeration.
REQ-033 One sub-module, servo_bus_wr, SHALL own the single-cycle write strobe generation and address computation (channel, offset -> addr).

Verification (PERIOD=1000, DMID=75, DMIN=50, DMAX=100, STEP_DIV=4)
REQ-034 Release rst -> 24 consecutive writes: addr 0x04=1000, 0x08=75, 0x00=1, ..., 0x58=1000, 0x5C=75, 0x54=1; then cmd_ready=1.
REQ-035 cmd ch=2, target=85, step=4 -> writes to 0x20 of 79, 83, 85 at +4, +8, +12 cycles; done one cycle after last.
REQ-036 cmd ch=7, target=20, step=0 -> single write 0x5C=50 at acceptance+1; done next cycle.
REQ-037 cmd ch=0, target=60, step=10 -> writes 65, 60 to 0x08; cmd_valid held during ramp sees cmd_ready=0 until after done.
REQ-038 rst asserted after second ramp write -> bus idle, no done, full 24-write INIT repeats, ch table back to 75.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared register map, FSM states and duty arithmetic for the servo ramp controller.
// Pure constants/functions: no latency, no flow control.
package servo_pkg;

    localparam logic [7:0] OFF_E     = 8'd0;
    localparam logic [7:0] OFF_T     = 8'd4;
    localparam logic [7:0] OFF_D     = 8'd8;
    localparam logic [7:0] CH_STRIDE = 8'd12;

    localparam int         NUM_CH      = 8;
    localparam logic [4:0] INIT_WRITES = 5'd24;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    function automatic logic [31:0] clamp_duty(input logic [31:0] t,
                                               input logic [31:0] lo,
                                               input logic [31:0] hi);
        if (t < lo)
            return lo;
        if (t > hi)
            return hi;
        return t;
    endfunction

    // One step toward tgt; the distance is compared first so the sum/difference never wraps or overshoots.
    function automatic logic [31:0] ramp_next(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [15:0] step);
        logic [31:0] step_w;
        step_w = {16'd0, step};
        if (tgt >= cur) begin
            if ((tgt - cur) <= step_w)
                return tgt;
            return cur + step_w;
        end
        if ((cur - tgt) <= step_w)
            return tgt;
        return cur - step_w;
    endfunction

endpackage

// File: rtl/servo_bus_wr.sv
// Registered single-cycle write strobe toward the PWM peripheral; addr = ch*12 + offset.
// One cycle from req to cs/wr; no backpressure, the peripheral accepts every write.
module servo_bus_wr
    import servo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  ch,
    input  logic [7:0]  off,
    input  logic [31:0] data,
    output logic        cs,
    output logic        wr,
    output logic        rd,
    output logic [7:0]  addr,
    output logic [31:0] bus_d
);

    always_ff @(posedge clk) begin
        if (rst || !req) begin
            cs    <= 1'b0;
            wr    <= 1'b0;
            addr  <= 8'd0;
            bus_d <= 32'd0;
        end else begin
            cs    <= 1'b1;
            wr    <= 1'b1;
            addr  <= ({5'd0, ch} * CH_STRIDE) + off;
            bus_d <= data;
        end
    end

    assign rd = 1'b0;

endmodule

// File: rtl/servo_ramp.sv
// Initialises an 8-channel PWM block, then ramps one channel's duty per command in timed steps.
// Bus write lands one cycle after it is decided; commands are held off (cmd_ready=0) while busy.
module servo_ramp
    import servo_pkg::*;
#(
    parameter logic [31:0] PERIOD   = 32'd1000000,
    parameter logic [31:0] DMID     = 32'd75000,
    parameter logic [31:0] DMIN     = 32'd50000,
    parameter logic [31:0] DMAX     = 32'd100000,
    parameter logic [31:0] STEP_DIV = 32'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_ch,
    input  logic [31:0] cmd_target,
    input  logic [15:0] cmd_step,
    output logic        busy,
    output logic        done,
    output logic        cs,
    output logic        wr,
    output logic        rd,
    output logic [7:0]  addr,
    output logic [31:0] bus_d
);

    // With a step interval of one cycle the ramp writes back-to-back and never waits.
    localparam logic FAST = (STEP_DIV <= 32'd1);

    state_t      state, state_nxt;
    logic [4:0]  idx, idx_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic        done_nxt;
    logic        accept;
    logic [2:0]  ch_q;
    logic [31:0] tgt_q;
    logic [15:0] step_q;
    logic [31:0] duty_tbl [NUM_CH];

    logic        req;
    logic [2:0]  req_ch;
    logic [7:0]  req_off;
    logic [31:0] req_data;
    logic [31:0] cur_cmd, tgt_cmd, cur_q;

    always_ff @(posedge clk) begin
        if (rst)
            state <= INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        accept    = 1'b0;
        req       = 1'b0;
        req_ch    = ch_q;
        req_off   = OFF_D;
        req_data  = 32'd0;
        cur_cmd   = duty_tbl[cmd_ch];
        tgt_cmd   = clamp_duty(cmd_target, DMIN, DMAX);
        cur_q     = duty_tbl[ch_q];

        unique case (state)
            INIT: begin
                if (idx == INIT_WRITES) begin
                    state_nxt = IDLE;
                end else begin
                    req     = 1'b1;
                    req_ch  = 3'(idx / 5'd3);
                    idx_nxt = idx + 5'd1;
                    case (idx % 5'd3)
                        5'd0:    begin req_off = OFF_T; req_data = PERIOD; end
                        5'd1:    begin req_off = OFF_D; req_data = DMID;   end
                        default: begin req_off = OFF_E; req_data = 32'd1;  end
                    endcase
                end
            end
            IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_step == 16'd0 || tgt_cmd == cur_cmd || FAST) begin
                        req       = 1'b1;
                        req_ch    = cmd_ch;
                        req_data  = (cmd_step == 16'd0) ? tgt_cmd
                                                        : ramp_next(cur_cmd, tgt_cmd, cmd_step);
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 32'd1;
                    end
                end
            end
            WAIT: begin
                if (cnt >= STEP_DIV - 32'd1) begin
                    req       = 1'b1;
                    req_data  = ramp_next(cur_q, tgt_q, step_q);
                    state_nxt = WRITE;
                    cnt_nxt   = 32'd0;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            WRITE: begin
                // The table already holds the value on the bus, so equality means this was the last step.
                if (cur_q == tgt_q) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (FAST) begin
                    req      = 1'b1;
                    req_data = ramp_next(cur_q, tgt_q, step_q);
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= 5'd0;
            cnt    <= 32'd0;
            done   <= 1'b0;
            ch_q   <= 3'd0;
            tgt_q  <= DMID;
            step_q <= 16'd0;
            for (int i = 0; i < NUM_CH; i++)
                duty_tbl[i] <= DMID;
        end else begin
            idx  <= idx_nxt;
            cnt  <= cnt_nxt;
            done <= done_nxt;
            if (accept) begin
                ch_q   <= cmd_ch;
                tgt_q  <= tgt_cmd;
                step_q <= cmd_step;
            end
            if (req && req_off == OFF_D)
                duty_tbl[req_ch] <= req_data;
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    servo_bus_wr u_bus_wr (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ch    (req_ch),
        .off   (req_off),
        .data  (req_data),
        .cs    (cs),
        .wr    (wr),
        .rd    (rd),
        .addr  (addr),
        .bus_d (bus_d)
    );

endmodule

// File: tb/tb_servo_ramp.sv
// Directed bench for servo_ramp: a cycle-stamped schedule of expected writes/done/ready is built
// from the ramp rules and compared against the DUT on every falling edge.
module tb_servo_ramp;

    localparam int INF = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_ch;
    logic [31:0] cmd_target;
    logic [15:0] cmd_step;
    logic        busy, done, cs, wr, rd;
    logic [7:0]  addr;
    logic [31:0] bus_d;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int ready_from;
    int mdl_duty [8];
    logic [39:0] exp_wr [int];
    bit          exp_done [int];

    servo_ramp #(
        .PERIOD   (32'd1000),
        .DMID     (32'd75),
        .DMIN     (32'd50),
        .DMAX     (32'd100),
        .STEP_DIV (32'd4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .busy       (busy),
        .done       (done),
        .cs         (cs),
        .wr         (wr),
        .rd         (rd),
        .addr       (addr),
        .bus_d      (bus_d)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, want);
        end
    endtask

    function automatic logic [39:0] wr_at(input int c);
        if (exp_wr.exists(c))
            return exp_wr[c];
        return {40{1'b1}};
    endfunction

    // Expected INIT sequence after reset is seen low for the first time in cycle r.
    task automatic plan_init(input int r);
        for (int n = 0; n < 8; n++) begin
            exp_wr[r + 1 + 3*n] = {8'(12*n + 4), 32'd1000};
            exp_wr[r + 2 + 3*n] = {8'(12*n + 8), 32'd75};
            exp_wr[r + 3 + 3*n] = {8'(12*n),     32'd1};
            mdl_duty[n] = 75;
        end
        ready_from = r + 25;
    endtask

    // Expected writes for a command accepted in cycle a: jump at a+1, else one step every 4 cycles.
    task automatic plan(input int a, input int ch, input int tgt, input int step);
        int t;
        int cur;
        int k;
        logic [7:0] ad;
        t   = (tgt < 50) ? 50 : ((tgt > 100) ? 100 : tgt);
        cur = mdl_duty[ch];
        k   = 0;
        ad  = 8'(12*ch + 8);
        if (step == 0 || t == cur) begin
            exp_wr[a + 1]   = {ad, 32'(t)};
            exp_done[a + 2] = 1'b1;
            ready_from      = a + 2;
        end else begin
            while (cur != t) begin
                k++;
                if (((t > cur) ? (t - cur) : (cur - t)) <= step)
                    cur = t;
                else if (t > cur)
                    cur = cur + step;
                else
                    cur = cur - step;
                exp_wr[a + 4*k] = {ad, 32'(cur)};
            end
            exp_done[a + 4*k + 1] = 1'b1;
            ready_from            = a + 4*k + 1;
        end
        mdl_duty[ch] = t;
    endtask

    // Called just after a rising edge; returns the acceptance cycle.
    task automatic send(input int ch, input int tgt, input int step, output int a);
        int waited;
        waited     = 0;
        cmd_ch     = 3'(ch);
        cmd_target = 32'(tgt);
        cmd_step   = 16'(step);
        cmd_valid  = 1'b1;
        while (cyc < ready_from && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        n_chk++;
        if (cyc < ready_from) begin
            n_fail++;
            $display("FAIL send_timeout ch=%0d got=no_accept want=accept", ch);
            cmd_valid = 1'b0;
            a = -1;
        end else begin
            a = cyc;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            plan(a, ch, tgt, step);
        end
    endtask

    task automatic apply_reset(input int n);
        int q;
        int ks[$];
        rst = 1'b1;
        q   = cyc;
        foreach (exp_wr[k]) if (k > q) ks.push_back(k);
        foreach (ks[i]) exp_wr.delete(ks[i]);
        ks.delete();
        foreach (exp_done[k]) if (k > q) ks.push_back(k);
        foreach (ks[i]) exp_done.delete(ks[i]);
        ready_from = INF;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        plan_init(cyc);
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            logic        e;
            logic [39:0] w;
            e = exp_wr.exists(cyc) != 0;
            w = e ? exp_wr[cyc] : 40'd0;
            check("bus", {21'd0, cs, wr, rd, addr, bus_d}, {21'd0, e, e, 1'b0, w});
            check("done", 64'(done), 64'(exp_done.exists(cyc) != 0));
            check("cmd_ready", 64'(cmd_ready), 64'(cyc >= ready_from));
            check("busy", 64'(busy), 64'(cyc < ready_from));
        end
    end

    initial begin
        int a;
        int r;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_ch     = 3'd0;
        cmd_target = 32'd0;
        cmd_step   = 16'd0;
        ready_from = INF;
        for (int i = 0; i < 8; i++) mdl_duty[i] = 75;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        r   = cyc;
        plan_init(r);
        check("pin_init_first", 64'(wr_at(r + 1)),  64'({8'h04, 32'd1000}));
        check("pin_init_d0",    64'(wr_at(r + 2)),  64'({8'h08, 32'd75}));
        check("pin_init_d7",    64'(wr_at(r + 23)), 64'({8'h5C, 32'd75}));
        check("pin_init_last",  64'(wr_at(r + 24)), 64'({8'h54, 32'd1}));

        send(2, 85, 4, a);
        check("pin_ch2_w1",  64'(wr_at(a + 4)),  64'({8'h20, 32'd79}));
        check("pin_ch2_w2",  64'(wr_at(a + 8)),  64'({8'h20, 32'd83}));
        check("pin_ch2_w3",  64'(wr_at(a + 12)), 64'({8'h20, 32'd85}));
        check("pin_ch2_done", 64'(exp_done.exists(a + 13) != 0), 64'd1);

        send(7, 20, 0, a);
        check("pin_ch7_jump", 64'(wr_at(a + 1)), 64'({8'h5C, 32'd50}));

        send(0, 60, 10, a);
        check("pin_ch0_w1", 64'(wr_at(a + 4)), 64'({8'h08, 32'd65}));
        check("pin_ch0_w2", 64'(wr_at(a + 8)), 64'({8'h08, 32'd60}));
        send(5, 200, 30, a);
        check("pin_ch5_clamp", 64'(wr_at(a + 4)), 64'({8'h44, 32'd100}));

        send(3, 90, 5, a);
        repeat (8) @(posedge clk);
        #1;
        apply_reset(2);
        send(3, 75, 3, a);
        check("pin_ch3_after_reset", 64'(wr_at(a + 1)), 64'({8'h2C, 32'd75}));

        for (int i = 0; i < 50 && cyc <= ready_from + 2; i++) begin
            @(posedge clk); #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
